// File: rtl/ising_axil_loader.sv
// -----------------------------------------------------------------------------
// ising_axil_loader
//
// AXI4-Lite slave that programs the 8x8 recurrent Ising sampler core and
// reads its results back. Data words written to the weight/noise/threshold
// offsets are streamed into the core memories at (row register, auto-
// incrementing column). Control offsets generate one-cycle clear/start pulses;
// read offsets return the packed spin state and a status word.
//
// Register map (byte offsets, addr[1:0] ignored):
//   0x00 W  weight data word     -> mem_sel = 0
//   0x04 W  noise data word      -> mem_sel = 1
//   0x08 W  threshold data word  -> mem_sel = 2
//   0x0C W  row register (col reset to 0) / R core_spins
//   0x10 R  status {27'b0, core_busy, core_done, start_drop, ovf, col_full}
//   0x14 W  bit0=1: start pulse (dropped and flagged while core_busy)
//   0x3C W  bit0=1: clear pulse, col/ovf/start_drop cleared
//
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*        AXI4-Lite write address/data/response channels
//   s_axi_ar*/r*           AXI4-Lite read address/data channels
//   mem_we/sel/row/col/wdata  one-cycle memory write toward the core
//   clear_pulse/start_pulse   one-cycle core controls
//   core_busy/done/spins      core status and result inputs
//
// Build option:
//   ISING_AXIL_SLVERR_EN  when defined, unmapped accesses and overflowing data
//                         writes answer SLVERR; otherwise every response is OKAY.
// -----------------------------------------------------------------------------
module ising_axil_loader #(
  parameter int C_ADDR_WIDTH = 6,
  parameter int C_DATA_WIDTH = 32,
  parameter int N_COL        = 8,
  parameter int ROW_W        = 11
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  // write address
  input  logic [C_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  // write data
  input  logic [C_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [3:0]              s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  // write response
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  // read address
  input  logic [C_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  // read data
  output logic [C_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  // core memory write port
  output logic                    mem_we,
  output logic [1:0]              mem_sel,
  output logic [ROW_W-1:0]        mem_row,
  output logic [2:0]              mem_col,
  output logic [C_DATA_WIDTH-1:0] mem_wdata,
  // core control / status
  output logic                    clear_pulse,
  output logic                    start_pulse,
  input  logic                    core_busy,
  input  logic                    core_done,
  input  logic [31:0]             core_spins
);

  localparam int COL_W = $clog2(N_COL + 1);
  localparam logic [COL_W-1:0] COL_FULL = COL_W'(N_COL);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Word offsets (byte offset >> 2)
  localparam logic [3:0] WO_WEIGHT = 4'h0;
  localparam logic [3:0] WO_NOISE  = 4'h1;
  localparam logic [3:0] WO_THRESH = 4'h2;
  localparam logic [3:0] WO_ROW    = 4'h3;  // write: row, read: spins
  localparam logic [3:0] WO_STATUS = 4'h4;
  localparam logic [3:0] WO_START  = 4'h5;
  localparam logic [3:0] WO_CLEAR  = 4'hF;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  w_state_e                w_state_q, w_state_d;
  logic                    rst_done_q;
  logic                    aw_held_q, aw_held_d;
  logic [3:0]              aw_word_q, aw_word_d;
  logic                    w_held_q, w_held_d;
  logic [C_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]              bresp_q, bresp_d;

  logic [ROW_W-1:0]        row_q, row_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic                    ovf_q, ovf_d;
  logic                    start_drop_q, start_drop_d;

  logic                    mem_we_q, mem_we_d;
  logic [1:0]              mem_sel_q, mem_sel_d;
  logic [2:0]              mem_col_q, mem_col_d;
  logic [C_DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                    clear_pulse_q, clear_pulse_d;
  logic                    start_pulse_q, start_pulse_d;

  logic                    rvalid_q, rvalid_d;
  logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;

  logic commit;
  logic wr_err;
  logic rd_err;
  logic ar_fire;
  logic col_full;
  logic [3:0] ar_word;

  // Address bits [1:0] and the byte strobes carry no meaning here.
  logic unused_ok;
  assign unused_ok = &{1'b0, s_axi_wstrb, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign col_full = (col_q == COL_FULL);
  assign ar_word  = s_axi_araddr[5:2];

  // ---------------------------------------------------------------------------
  // Write FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
    end else begin
      w_state_q <= w_state_d;
    end
  end

  // Write FSM: next state. A write commits on the cycle both halves are held.
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_held_q && w_held_q) w_state_d = W_RESP;
      W_RESP:  if (s_axi_bready)          w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM: outputs. Each channel stops accepting once its half is held,
  // and both stay closed until the response handshake.
  always_comb begin
    s_axi_awready = rst_done_q && (w_state_q == W_IDLE) && !aw_held_q;
    s_axi_wready  = rst_done_q && (w_state_q == W_IDLE) && !w_held_q;
    s_axi_bvalid  = (w_state_q == W_RESP);
  end

  assign commit = (w_state_q == W_IDLE) && aw_held_q && w_held_q;

  // ---------------------------------------------------------------------------
  // Write channel capture and commit datapath
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    aw_held_d     = aw_held_q;
    aw_word_d     = aw_word_q;
    w_held_d      = w_held_q;
    wdata_d       = wdata_q;
    bresp_d       = bresp_q;
    row_d         = row_q;
    col_d         = col_q;
    ovf_d         = ovf_q;
    start_drop_d  = start_drop_q;
    mem_we_d      = 1'b0;
    mem_sel_d     = mem_sel_q;
    mem_col_d     = mem_col_q;
    mem_wdata_d   = mem_wdata_q;
    clear_pulse_d = 1'b0;
    start_pulse_d = 1'b0;
    wr_err        = 1'b0;

    if (s_axi_awvalid && s_axi_awready) begin
      aw_held_d = 1'b1;
      aw_word_d = s_axi_awaddr[5:2];
    end
    if (s_axi_wvalid && s_axi_wready) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi_wdata;
    end

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      case (aw_word_q)
        WO_WEIGHT, WO_NOISE, WO_THRESH: begin
          if (!col_full) begin
            mem_we_d    = 1'b1;
            mem_sel_d   = aw_word_q[1:0];
            mem_col_d   = col_q[2:0];
            mem_wdata_d = wdata_q;
            col_d       = col_q + COL_W'(1);
          end else begin
            ovf_d  = 1'b1;
            wr_err = 1'b1;
          end
        end
        WO_ROW: begin
          row_d = wdata_q[ROW_W-1:0];
          col_d = '0;
        end
        WO_START: begin
          if (wdata_q[0]) begin
            if (!core_busy) start_pulse_d = 1'b1;
            else            start_drop_d  = 1'b1;
          end
        end
        WO_CLEAR: begin
          if (wdata_q[0]) begin
            clear_pulse_d = 1'b1;
            col_d         = '0;
            ovf_d         = 1'b0;
            start_drop_d  = 1'b0;
          end
        end
        default: wr_err = 1'b1;
      endcase
`ifdef ISING_AXIL_SLVERR_EN
      bresp_d = wr_err ? RESP_SLVERR : RESP_OKAY;
`else
      bresp_d = RESP_OKAY;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel: registered data, one read in flight
  // ---------------------------------------------------------------------------
  assign ar_fire = s_axi_arvalid && s_axi_arready;

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rd_err   = 1'b0;
    if (ar_fire) begin
      rvalid_d = 1'b1;
      case (ar_word)
        WO_ROW:    rdata_d = core_spins;
        WO_STATUS: rdata_d = {{(C_DATA_WIDTH-5){1'b0}}, core_busy, core_done,
                              start_drop_q, ovf_q, col_full};
        default: begin
          rdata_d = '0;
          rd_err  = 1'b1;
        end
      endcase
`ifdef ISING_AXIL_SLVERR_EN
      rresp_d = rd_err ? RESP_SLVERR : RESP_OKAY;
`else
      rresp_d = RESP_OKAY;
`endif
    end else if (s_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rst_done_q    <= 1'b0;
      aw_held_q     <= 1'b0;
      aw_word_q     <= '0;
      w_held_q      <= 1'b0;
      wdata_q       <= '0;
      bresp_q       <= RESP_OKAY;
      row_q         <= '0;
      col_q         <= '0;
      ovf_q         <= 1'b0;
      start_drop_q  <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_sel_q     <= '0;
      mem_col_q     <= '0;
      mem_wdata_q   <= '0;
      clear_pulse_q <= 1'b0;
      start_pulse_q <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      rresp_q       <= RESP_OKAY;
    end else begin
      // Holds the ready outputs low while reset is asserted and opens them on
      // the first clock edge after release.
      rst_done_q    <= 1'b1;
      aw_held_q     <= aw_held_d;
      aw_word_q     <= aw_word_d;
      w_held_q      <= w_held_d;
      wdata_q       <= wdata_d;
      bresp_q       <= bresp_d;
      row_q         <= row_d;
      col_q         <= col_d;
      ovf_q         <= ovf_d;
      start_drop_q  <= start_drop_d;
      mem_we_q      <= mem_we_d;
      mem_sel_q     <= mem_sel_d;
      mem_col_q     <= mem_col_d;
      mem_wdata_q   <= mem_wdata_d;
      clear_pulse_q <= clear_pulse_d;
      start_pulse_q <= start_pulse_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
      rresp_q       <= rresp_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = rst_done_q && !rvalid_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

  assign mem_we      = mem_we_q;
  assign mem_sel     = mem_sel_q;
  assign mem_row     = row_q;
  assign mem_col     = mem_col_q;
  assign mem_wdata   = mem_wdata_q;
  assign clear_pulse = clear_pulse_q;
  assign start_pulse = start_pulse_q;

endmodule

// File: tb/tb_ising_axil_loader.sv
// -----------------------------------------------------------------------------
// tb_ising_axil_loader
//
// Directed bench for ising_axil_loader: memory streaming with row/column
// addressing, column overflow, out-of-order AW/W with response back-pressure,
// start/clear pulses with the drop flag, spin readback under rready stall,
// unmapped accesses and reset in the middle of a write.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ising_axil_loader;

`ifdef ISING_AXIL_SLVERR_EN
  localparam logic [1:0] ERR_RESP = 2'b10;
`else
  localparam logic [1:0] ERR_RESP = 2'b00;
`endif

  logic        aclk;
  logic        aresetn;
  logic [5:0]  s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [5:0]  s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic        mem_we;
  logic [1:0]  mem_sel;
  logic [10:0] mem_row;
  logic [2:0]  mem_col;
  logic [31:0] mem_wdata;
  logic        clear_pulse;
  logic        start_pulse;
  logic        core_busy;
  logic        core_done;
  logic [31:0] core_spins;

  ising_axil_loader dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .mem_we        (mem_we),
    .mem_sel       (mem_sel),
    .mem_row       (mem_row),
    .mem_col       (mem_col),
    .mem_wdata     (mem_wdata),
    .clear_pulse   (clear_pulse),
    .start_pulse   (start_pulse),
    .core_busy     (core_busy),
    .core_done     (core_done),
    .core_spins    (core_spins)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Output monitor (samples on the falling edge)
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [1:0]  sel;
    logic [10:0] row;
    logic [2:0]  col;
    logic [31:0] data;
  } mem_ev_t;

  mem_ev_t mem_q[$];
  int      clear_cnt = 0;
  int      start_cnt = 0;

  always @(negedge aclk) begin
    if (mem_we) mem_q.push_back({mem_sel, mem_row, mem_col, mem_wdata});
    if (clear_pulse) clear_cnt++;
    if (start_pulse) start_cnt++;
  end

  task automatic expect_mem(input string tag, input logic [1:0] sel, input logic [10:0] row,
                            input logic [2:0] col, input logic [31:0] data);
    mem_ev_t got;
    mem_ev_t exp;
    exp = {sel, row, col, data};
    if (mem_q.size() == 0) begin
      check({tag, "_missing"}, 64'd0, 64'd1);
    end else begin
      got = mem_q.pop_front();
      check(tag, 64'(got), 64'(exp));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Bus tasks
  // ---------------------------------------------------------------------------
  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, output logic [1:0] resp);
    int   n;
    logic aw_done, w_done, aw_fire, w_fire;
    @(negedge aclk);
    s_axi_awaddr  = addr;
    s_axi_awvalid = 1'b1;
    s_axi_wdata   = data;
    s_axi_wvalid  = 1'b1;
    s_axi_bready  = 1'b1;
    aw_done = 1'b0;
    w_done  = 1'b0;
    n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      aw_fire = s_axi_awvalid && s_axi_awready;
      w_fire  = s_axi_wvalid && s_axi_wready;
      @(negedge aclk);
      n++;
      if (aw_fire) begin s_axi_awvalid = 1'b0; aw_done = 1'b1; end
      if (w_fire)  begin s_axi_wvalid  = 1'b0; w_done  = 1'b1; end
    end
    if (!(aw_done && w_done)) begin
      check("aw_w_timeout", 64'd0, 64'd1);
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
    end
    n = 0;
    while (!s_axi_bvalid && n < 20) begin
      @(negedge aclk);
      n++;
    end
    if (s_axi_bvalid) begin
      resp = s_axi_bresp;
      @(negedge aclk);
    end else begin
      check("b_timeout", 64'd0, 64'd1);
      resp = 2'b11;
    end
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read_check(input string tag, input logic [5:0] addr, input int hold,
                                input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int n;
    @(negedge aclk);
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    s_axi_rready  = 1'b0;
    n = 0;
    while (!s_axi_arready && n < 20) begin
      @(negedge aclk);
      n++;
    end
    if (!s_axi_arready) begin
      check({tag, "_ar_timeout"}, 64'd0, 64'd1);
      s_axi_arvalid = 1'b0;
      return;
    end
    @(negedge aclk);
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin
      @(negedge aclk);
      n++;
    end
    if (!s_axi_rvalid) begin
      check({tag, "_r_timeout"}, 64'd0, 64'd1);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      check({tag, "_held"}, {s_axi_rvalid, s_axi_arready, s_axi_rdata}, {1'b1, 1'b0, exp_data});
      @(negedge aclk);
    end
    s_axi_rready = 1'b1;
    check(tag, {s_axi_rresp, s_axi_rdata}, {exp_resp, exp_data});
    @(negedge aclk);
    s_axi_rready = 1'b0;
    check({tag, "_rvalid_clr"}, 64'(s_axi_rvalid), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [1:0] resp;

  initial begin
    aresetn       = 1'b0;
    s_axi_awaddr  = '0;
    s_axi_awvalid = 1'b0;
    s_axi_wdata   = '0;
    s_axi_wstrb   = 4'hF;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b0;
    s_axi_araddr  = '0;
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b0;
    core_busy     = 1'b0;
    core_done     = 1'b0;
    core_spins    = '0;

    // Reset state
    repeat (3) @(negedge aclk);
    check("rst_handshake", {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid}, 64'd0);
    check("rst_core_if", {mem_we, clear_pulse, start_pulse, mem_sel, mem_col, mem_row}, 64'd0);
    check("rst_resp_data", {s_axi_bresp, s_axi_rresp, s_axi_rdata, mem_wdata}, 64'd0);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    check("post_rst_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 64'h7);

    // Clear, row 1, eight weight words alternating 0/3
    axi_write(6'h3C, 32'h1, resp);
    check("clear_bresp", 64'(resp), 64'd0);
    check("clear_cnt_1", 64'(clear_cnt), 64'd1);
    axi_write(6'h0C, 32'h1, resp);
    check("row1", 64'(mem_row), 64'd1);
    for (int i = 0; i < 8; i++) begin
      axi_write(6'h00, (i % 2 == 1) ? 32'd3 : 32'd0, resp);
      check("wt_bresp", 64'(resp), 64'd0);
    end
    repeat (2) @(negedge aclk);
    for (int i = 0; i < 8; i++)
      expect_mem("wt_word", 2'd0, 11'd1, 3'(i), (i % 2 == 1) ? 32'd3 : 32'd0);
    check("clear_cnt_still_1", 64'(clear_cnt), 64'd1);

    // Ninth word overflows
    axi_write(6'h00, 32'hDEAD_BEEF, resp);
    check("ovf_bresp", 64'(resp), 64'(ERR_RESP));
    repeat (2) @(negedge aclk);
    check("ovf_no_we", 64'(mem_q.size()), 64'd0);
    axi_read_check("status_ovf", 6'h10, 0, 32'h0000_0003, 2'b00);

    // Clear, row 0x402, two noise words
    axi_write(6'h3C, 32'h1, resp);
    check("clear_cnt_2", 64'(clear_cnt), 64'd2);
    axi_write(6'h0C, 32'h402, resp);
    check("row402", 64'(mem_row), 64'h402);
    axi_write(6'h04, 32'hFFFF_FFFF, resp);
    axi_write(6'h04, 32'hFFFF_FFFE, resp);
    repeat (2) @(negedge aclk);
    expect_mem("noise0", 2'd1, 11'h402, 3'd0, 32'hFFFF_FFFF);
    expect_mem("noise1", 2'd1, 11'h402, 3'd1, 32'hFFFF_FFFE);

    // W three cycles ahead of AW, response held off four cycles
    @(negedge aclk);
    s_axi_wdata  = 32'h1234_5678;
    s_axi_wvalid = 1'b1;
    s_axi_bready = 1'b0;
    check("wfirst_wready", 64'(s_axi_wready), 64'd1);
    @(negedge aclk);
    s_axi_wvalid = 1'b0;
    @(negedge aclk);
    check("wfirst_w_closed", {s_axi_wready, s_axi_awready, s_axi_bvalid}, 64'h2);
    @(negedge aclk);
    s_axi_awaddr  = 6'h04;
    s_axi_awvalid = 1'b1;
    @(negedge aclk);
    s_axi_awvalid = 1'b0;
    check("wfirst_aw_closed", {s_axi_awready, s_axi_wready}, 64'd0);
    @(negedge aclk);
    for (int i = 0; i < 4; i++) begin
      check("wfirst_b_hold", {s_axi_bvalid, s_axi_awready, s_axi_wready}, 64'h4);
      @(negedge aclk);
    end
    s_axi_bready = 1'b1;
    @(negedge aclk);
    s_axi_bready = 1'b0;
    check("wfirst_b_done", {s_axi_bvalid, s_axi_awready, s_axi_wready}, 64'h3);
    @(negedge aclk);
    expect_mem("wfirst_word", 2'd1, 11'h402, 3'd2, 32'h1234_5678);
    check("wfirst_single", 64'(mem_q.size()), 64'd0);

    // Start pulse, then a dropped start while busy
    axi_write(6'h14, 32'h1, resp);
    @(negedge aclk);
    check("start_cnt_1", 64'(start_cnt), 64'd1);
    core_busy = 1'b1;
    axi_write(6'h14, 32'h1, resp);
    axi_write(6'h14, 32'h0, resp);
    @(negedge aclk);
    check("start_dropped", 64'(start_cnt), 64'd1);
    axi_read_check("status_drop", 6'h10, 0, 32'h0000_0014, 2'b00);
    axi_write(6'h3C, 32'h0, resp);
    @(negedge aclk);
    check("clear_zero_noop", 64'(clear_cnt), 64'd2);
    axi_write(6'h3C, 32'h1, resp);
    @(negedge aclk);
    check("clear_cnt_3", 64'(clear_cnt), 64'd3);
    axi_read_check("status_cleared", 6'h10, 0, 32'h0000_0010, 2'b00);
    check("row_kept", 64'(mem_row), 64'h402);

    // Spin readback under rready stall
    core_busy  = 1'b0;
    core_done  = 1'b1;
    core_spins = 32'hA5A5_0F0F;
    axi_read_check("spins", 6'h0C, 2, 32'hA5A5_0F0F, 2'b00);
    axi_read_check("status_done", 6'h10, 0, 32'h0000_0008, 2'b00);

    // Unmapped accesses
    axi_read_check("unmapped_rd", 6'h20, 0, 32'h0, ERR_RESP);
    axi_write(6'h30, 32'h1, resp);
    check("unmapped_bresp", 64'(resp), 64'(ERR_RESP));
    repeat (2) @(negedge aclk);
    check("unmapped_no_effect", {32'(mem_q.size()), 8'(clear_cnt), 8'(start_cnt)}, {32'd0, 8'd3, 8'd1});

    // Reset between handshake and commit discards the write
    @(negedge aclk);
    s_axi_awaddr  = 6'h00;
    s_axi_wdata   = 32'h55;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    s_axi_bready  = 1'b1;
    @(negedge aclk);
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    check("midrst_quiet", {s_axi_bvalid, s_axi_awready, mem_we, mem_row}, 64'd0);
    check("midrst_no_we", 64'(mem_q.size()), 64'd0);
    aresetn = 1'b1;
    s_axi_bready = 1'b0;
    repeat (2) @(negedge aclk);
    axi_write(6'h00, 32'h7, resp);
    repeat (2) @(negedge aclk);
    expect_mem("post_midrst_word", 2'd0, 11'd0, 3'd0, 32'h7);
    check("post_midrst_single", 64'(mem_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ising_axil_loader.md
Name: ising_axil_loader

Overview:
- AXI4-Lite slave that lets the PS/VIP master program the 8x8 recurrent Ising sampler core and read results back.
- Decodes register offsets and streams data words into the core's weight/noise/threshold memories, using a row register and an auto-incrementing column counter.
- Generates one-cycle clear/start pulses and returns the core's spin state and status.
- Sits directly between the AXI interconnect (axi_vip master port) and the sampler core.

Parameters:
C_ADDR_WIDTH, 6, AXI offset bits decoded (byte address; [1:0] ignored)
C_DATA_WIDTH, 32, AXI data width; fixed at 32
N_COL, 8, words per row before overflow
ROW_W, 11, width of row register (0x000-0x3FF weights, 0x400 threshold, 0x401-0x402 noise)

Ports:
aclk  in  1  system clock
aresetn  in  1  asynchronous active-low reset
s_axi_awaddr/awvalid/awready  in/in/out  C_ADDR_WIDTH/1/1  write address channel
s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel (wstrb ignored, full-word writes)
s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response
s_axi_araddr/arvalid/arready  in/in/out  C_ADDR_WIDTH/1/1  read address
s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data
mem_we  out  1  one-cycle memory write strobe
mem_sel  out  2  0=weight(0x00), 1=noise(0x04), 2=threshold(0x08)
mem_row  out  ROW_W  current row register
mem_col  out  3  column index of this write
mem_wdata  out  32  data word
clear_pulse  out  1  one-cycle core clear
start_pulse  out  1  one-cycle core start
core_busy  in  1  core computing
core_done  in  1  core finished, spins valid
core_spins  in  32  packed spin result

Behaviour:
- Reset (async, aresetn=0): all ready/valid low, bresp=rresp=0, rdata=0, mem_* =0, pulses=0, row=0, col=0, sticky flags=0. Deasserted synchronously to aclk.
- Write FSM W_IDLE -> W_RESP: awready/wready high in W_IDLE. AW and W are latched independently in any order. Once both are held, the write commits in the following cycle and bvalid rises in that same cycle (W_RESP). awready/wready stay low until bready&&bvalid, then return to W_IDLE. One outstanding write.
- Offsets:
  - 0x00/0x04/0x08: data write. If col<N_COL: mem_we=1 for the commit cycle, with mem_sel/mem_row/mem_col=col/mem_wdata; then col++. If col==N_COL: no mem_we, sticky ovf=1.
  - 0x0C write: row <= wdata[ROW_W-1:0], col <= 0.
  - 0x14 write bit0=1: start_pulse for 1 cycle if !core_busy; else no pulse and sticky start_drop=1.
  - 0x3C write bit0=1: clear_pulse for 1 cycle; col<=0, ovf<=0, start_drop<=0. row unchanged.
  - Write of 0 to 0x14/0x3C: no effect.
- Read FSM: arready high when !rvalid. On AR handshake, rdata is registered and rvalid rises the next cycle, held until rready.
  - 0x0C reads core_spins.
  - 0x10 reads status {27'b0, core_busy, core_done, start_drop, ovf, col==N_COL}.
  - Other offsets read 0.
- Simultaneous write commit and read: independent; both serviced the same cycle.
- Data write in the same commit cycle as core_busy: still performed; gating is the core's responsibility.
- Reset mid-transaction: all channels drop immediately, in-flight write is discarded, no mem_we.
- bresp/rresp: OKAY (2'b00) except as noted under Optional Feature.

Optional Feature:
- ISING_AXIL_SLVERR_EN defined: writes to unmapped offsets and data writes rejected by overflow return bresp=SLVERR (2'b10); reads of unmapped offsets return rresp=SLVERR with rdata=0.
- Undefined: all responses OKAY, unmapped accesses silently ignored.

Test Plan:
- Reset, write 0x3C=1, 0x0C=0x1, then eight writes to 0x00 alternating 0/3 -> eight mem_we pulses, mem_sel=0, mem_row=1, mem_col 0..7, wdata matches; one clear_pulse.
- Ninth 0x00 write without clear -> no mem_we; read 0x10 returns bit1 (ovf)=1 and bit0=1; with SLVERR_EN, bresp=2'b10.
- Row 0x402, noise writes 0xFFFFFFFF, 0xFFFFFFFE -> mem_sel=1, mem_row=0x402, wdata exact, col 0 then 1.
- W channel presented 3 cycles before AW, bready held low 4 cycles -> single commit; bvalid held; no second write accepted until B handshake.
- Write 0x14=1 with core_busy=0 -> one start_pulse. Repeat with core_busy=1 -> no pulse, status bit2=1. Clear -> bit2=0.
- core_done=1, core_spins=0xA5A5_0F0F; read 0x0C with rready low 2 cycles -> rdata=0xA5A50F0F held stable, rresp=0.
